// File: rtl/dcache_pkg.sv
// Shared constants, FSM state encoding and address-split helpers for the
// direct-mapped write-back data cache.
package dcache_pkg;

  localparam int unsigned ADDR_W         = 32;
  localparam int unsigned DATA_W         = 32;
  localparam int unsigned INDEX_W        = 4;
  localparam int unsigned OFFSET_W       = 5;
  localparam int unsigned LINE_W         = 8 << OFFSET_W;
  localparam int unsigned TAG_W          = ADDR_W - INDEX_W - OFFSET_W;
  localparam int unsigned WORD_SEL_W     = OFFSET_W - 2;
  localparam int unsigned WORDS_PER_LINE = 1 << WORD_SEL_W;
  localparam int unsigned NUM_SETS       = 1 << INDEX_W;

  typedef enum logic [1:0] {
    StIdle      = 2'd0,
    StWriteback = 2'd1,
    StAllocate  = 2'd2
  } dcache_state_e;

  function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] addr);
    return addr[ADDR_W-1 -: TAG_W];
  endfunction

  function automatic logic [INDEX_W-1:0] addr_index(input logic [ADDR_W-1:0] addr);
    return addr[OFFSET_W +: INDEX_W];
  endfunction

  function automatic logic [WORD_SEL_W-1:0] addr_word(input logic [ADDR_W-1:0] addr);
    return addr[2 +: WORD_SEL_W];
  endfunction

  function automatic logic [ADDR_W-1:0] line_addr(input logic [TAG_W-1:0]   tag,
                                                  input logic [INDEX_W-1:0] index);
    return {tag, index, {OFFSET_W{1'b0}}};
  endfunction

  function automatic logic [DATA_W-1:0] line_word(input logic [LINE_W-1:0]     line,
                                                  input logic [WORD_SEL_W-1:0] sel);
    logic [DATA_W-1:0] word;
    word = '0;
    for (int w = 0; w < WORDS_PER_LINE; w++) begin
      if (sel == w[WORD_SEL_W-1:0]) word = line[w*DATA_W +: DATA_W];
    end
    return word;
  endfunction

endpackage

// File: rtl/dcache_tag_data_array.sv
// Per-set valid/dirty/tag/line storage. Valid and dirty clear asynchronously;
// tag and line contents are don't-care until a fill. Reads are combinational.
module dcache_tag_data_array import dcache_pkg::*; (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [INDEX_W-1:0]    rd_index_i,
  output logic                  rd_valid_o,
  output logic                  rd_dirty_o,
  output logic [TAG_W-1:0]      rd_tag_o,
  output logic [LINE_W-1:0]     rd_line_o,
  input  logic                  word_we_i,
  input  logic [INDEX_W-1:0]    word_index_i,
  input  logic [WORD_SEL_W-1:0] word_sel_i,
  input  logic [DATA_W-1:0]     word_data_i,
  input  logic                  clean_i,
  input  logic [INDEX_W-1:0]    clean_index_i,
  input  logic                  fill_we_i,
  input  logic [INDEX_W-1:0]    fill_index_i,
  input  logic [TAG_W-1:0]      fill_tag_i,
  input  logic [LINE_W-1:0]     fill_line_i
);

  logic [NUM_SETS-1:0] valid_q;
  logic [NUM_SETS-1:0] dirty_q;
  logic [TAG_W-1:0]    tag_q  [NUM_SETS];
  logic [LINE_W-1:0]   line_q [NUM_SETS];

  // Valid/dirty state; a store hit marks its set dirty, a fill or writeback cleans it.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      if (fill_we_i) begin
        valid_q[fill_index_i] <= 1'b1;
        dirty_q[fill_index_i] <= 1'b0;
      end
      if (clean_i) dirty_q[clean_index_i] <= 1'b0;
      if (word_we_i) dirty_q[word_index_i] <= 1'b1;
    end
  end

  // Tag and line payload; no reset since valid gates every use.
  always_ff @(posedge clk_i) begin
    if (fill_we_i) begin
      tag_q[fill_index_i]  <= fill_tag_i;
      line_q[fill_index_i] <= fill_line_i;
    end
    if (word_we_i) begin
      for (int w = 0; w < WORDS_PER_LINE; w++) begin
        if (word_sel_i == w[WORD_SEL_W-1:0]) begin
          line_q[word_index_i][w*DATA_W +: DATA_W] <= word_data_i;
        end
      end
    end
  end

  assign rd_valid_o = valid_q[rd_index_i];
  assign rd_dirty_o = dirty_q[rd_index_i];
  assign rd_tag_o   = tag_q[rd_index_i];
  assign rd_line_o  = line_q[rd_index_i];

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped, write-back, write-allocate data cache controller.
// Hits complete in the same cycle; misses stall the CPU while a line is
// written back (if dirty) and refilled over a req/ack memory port.
// Optional DCACHE_STATS_EN adds saturating hit/miss counters.
module dcache_controller import dcache_pkg::*; (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_data_i,
  output logic [DATA_W-1:0] cpu_data_o,
  output logic              cpu_stall_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [LINE_W-1:0] mem_data_o,
  input  logic [LINE_W-1:0] mem_data_i,
  input  logic              mem_ack_i
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]       hit_cnt_o,
  output logic [31:0]       miss_cnt_o
`endif
);

  dcache_state_e state_q, state_d;
  logic [TAG_W-1:0]   miss_tag_q, miss_tag_d;
  logic [INDEX_W-1:0] miss_index_q, miss_index_d;

  logic [TAG_W-1:0]      cpu_tag;
  logic [INDEX_W-1:0]    cpu_index;
  logic [WORD_SEL_W-1:0] cpu_word;
  logic [INDEX_W-1:0]    rd_index;
  logic                  rd_valid, rd_dirty;
  logic [TAG_W-1:0]      rd_tag;
  logic [LINE_W-1:0]     rd_line;
  logic                  hit;
  logic                  word_we, clean, fill_we;

  // Byte-lane bits are not used by a word-granular cache.
  logic unused_addr_bits;
  assign unused_addr_bits = ^cpu_addr_i[1:0];

  assign cpu_tag   = addr_tag(cpu_addr_i);
  assign cpu_index = addr_index(cpu_addr_i);
  assign cpu_word  = addr_word(cpu_addr_i);

  // While a miss is in flight the array is looked up at the latched set, so the
  // victim tag/line stay stable for the writeback regardless of CPU inputs.
  assign rd_index = (state_q == StIdle) ? cpu_index : miss_index_q;
  assign hit      = cpu_req_i & rd_valid & (rd_tag == cpu_tag);

  dcache_tag_data_array u_array (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .rd_index_i    (rd_index),
    .rd_valid_o    (rd_valid),
    .rd_dirty_o    (rd_dirty),
    .rd_tag_o      (rd_tag),
    .rd_line_o     (rd_line),
    .word_we_i     (word_we),
    .word_index_i  (cpu_index),
    .word_sel_i    (cpu_word),
    .word_data_i   (cpu_data_i),
    .clean_i       (clean),
    .clean_index_i (miss_index_q),
    .fill_we_i     (fill_we),
    .fill_index_i  (miss_index_q),
    .fill_tag_i    (miss_tag_q),
    .fill_line_i   (mem_data_i)
  );

  // State and latched miss address.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= StIdle;
      miss_tag_q   <= '0;
      miss_index_q <= '0;
    end else begin
      state_q      <= state_d;
      miss_tag_q   <= miss_tag_d;
      miss_index_q <= miss_index_d;
    end
  end

  // Next state, CPU/memory outputs and array write strobes.
  always_comb begin
    state_d      = state_q;
    miss_tag_d   = miss_tag_q;
    miss_index_d = miss_index_q;
    cpu_data_o   = '0;
    cpu_stall_o  = 1'b0;
    mem_req_o    = 1'b0;
    mem_we_o     = 1'b0;
    mem_addr_o   = '0;
    mem_data_o   = '0;
    word_we      = 1'b0;
    clean        = 1'b0;
    fill_we      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (cpu_req_i) begin
          if (hit) begin
            if (cpu_we_i) word_we = 1'b1;
            else          cpu_data_o = line_word(rd_line, cpu_word);
          end else begin
            cpu_stall_o  = 1'b1;
            miss_tag_d   = cpu_tag;
            miss_index_d = cpu_index;
            state_d      = (rd_valid & rd_dirty) ? StWriteback : StAllocate;
          end
        end
      end
      StWriteback: begin
        cpu_stall_o = 1'b1;
        mem_req_o   = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = line_addr(rd_tag, miss_index_q);
        mem_data_o  = rd_line;
        if (mem_ack_i) begin
          clean   = 1'b1;
          state_d = StAllocate;
        end
      end
      StAllocate: begin
        cpu_stall_o = 1'b1;
        mem_req_o   = 1'b1;
        mem_addr_o  = line_addr(miss_tag_q, miss_index_q);
        if (mem_ack_i) begin
          fill_we = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Reset silences every output at once, even with a CPU request still held.
    if (!rst_i) begin
      state_d     = StIdle;
      cpu_data_o  = '0;
      cpu_stall_o = 1'b0;
      mem_req_o   = 1'b0;
      mem_we_o    = 1'b0;
      mem_addr_o  = '0;
      mem_data_o  = '0;
      word_we     = 1'b0;
      clean       = 1'b0;
      fill_we     = 1'b0;
    end
  end

`ifdef DCACHE_STATS_EN
  logic        refill_done_q;
  logic [31:0] hit_cnt_q, miss_cnt_q;
  logic        idle_hit, idle_miss;

  assign idle_hit  = (state_q == StIdle) & hit & ~refill_done_q;
  assign idle_miss = (state_q == StIdle) & cpu_req_i & ~hit;

  // Saturating counters; the hit that retires a refilled miss is not a hit.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      refill_done_q <= 1'b0;
      hit_cnt_q     <= '0;
      miss_cnt_q    <= '0;
    end else begin
      refill_done_q <= fill_we;
      if (idle_hit && hit_cnt_q != 32'hFFFF_FFFF)   hit_cnt_q  <= hit_cnt_q + 32'd1;
      if (idle_miss && miss_cnt_q != 32'hFFFF_FFFF) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;
`endif

endmodule
